// File: rtl/conv_encoder_punct_pkg.sv
// Shared types and constant tables for the punctured convolutional encoder.
// Generator polynomials are stored left-aligned in GEN_W bits: the MSB taps the
// current input bit and bit (GEN_W-2-i) taps shift-register bit sr[i].
// Bits below a smaller code's constraint length are zero, so unused
// shift-register stages drop out of the parity sums without any extra masking.
package conv_enc_pkg;

    localparam int GEN_W = 7;

    typedef enum logic [1:0] {
        K_SEL_3 = 2'd0,
        K_SEL_4 = 2'd1,
        K_SEL_5 = 2'd2,
        K_SEL_7 = 2'd3
    } k_sel_e;

    typedef enum logic [1:0] {
        RATE_1_2  = 2'd0,
        RATE_2_3  = 2'd1,
        RATE_3_4  = 2'd2,
        RATE_RSVD = 2'd3
    } rate_sel_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DATA  = 2'd1,
        ST_TAIL  = 2'd2,
        ST_DRAIN = 2'd3
    } enc_state_e;

    // Indexed by constraint_sel: K3 (7,5), K4 (15,17), K5 (23,35), K7 (171,133)
    localparam logic [3:0][GEN_W-1:0] GEN0_TBL = {
        7'b1111001, 7'b1001100, 7'b1101000, 7'b1110000
    };
    localparam logic [3:0][GEN_W-1:0] GEN1_TBL = {
        7'b1011011, 7'b1110100, 7'b1111000, 7'b1010000
    };

    // Puncture masks indexed [rate_sel][p]; bit0 keeps c0, bit1 keeps c1.
    // The reserved rate behaves exactly like rate 1/2.
    localparam logic [3:0][2:0][1:0] PUNCT_MASK_TBL = {
        2'b11, 2'b11, 2'b11,
        2'b10, 2'b01, 2'b11,
        2'b11, 2'b01, 2'b11,
        2'b11, 2'b11, 2'b11
    };
    localparam logic [3:0][1:0] PUNCT_PERIOD_TBL = {2'd1, 2'd3, 2'd2, 2'd1};

    function automatic logic [2:0] k_of(input logic [1:0] sel);
        logic [2:0] k;
        case (k_sel_e'(sel))
            K_SEL_3: k = 3'd3;
            K_SEL_4: k = 3'd4;
            K_SEL_5: k = 3'd5;
            default: k = 3'd7;
        endcase
        return k;
    endfunction

endpackage

// File: rtl/conv_encoder_punct_if.sv
// Configuration, bit-input and coded-bit-output handshake bundle of the encoder.
// The master side is the bit source / downstream sink; the slave side is the encoder.
interface conv_encoder_punct_if #(
    parameter int LEN_W = 8
);
    logic [1:0]       constraint_sel;
    logic [1:0]       rate_sel;
    logic [LEN_W-1:0] frame_len;
    logic             start;
    logic             busy;
    logic             in_valid;
    logic             in_data;
    logic             in_ready;
    logic             out_valid;
    logic             out_bit;
    logic             out_last;
    logic             out_ready;

    modport master (
        output constraint_sel, rate_sel, frame_len, start, in_valid, in_data, out_ready,
        input  busy, in_ready, out_valid, out_bit, out_last
    );

    modport slave (
        input  constraint_sel, rate_sel, frame_len, start, in_valid, in_data, out_ready,
        output busy, in_ready, out_valid, out_bit, out_last
    );
endinterface

// File: rtl/conv_encoder_punct_ser.sv
// Two-bit puncturing serializer: loads the surviving coded bits of one encoding
// step and hands them downstream one at a time, c0 before c1. A load is only
// issued while the serializer is empty, so load and pop never collide.
module conv_puncture_ser
    import conv_enc_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic       c0,
    input  logic       c1,
    input  logic [1:0] mask,
    input  logic       last_in,
    output logic       empty,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       out_bit,
    output logic       out_last
);
    logic [1:0] cnt_q;
    logic       bit0_q;
    logic       bit1_q;
    logic       last_q;

    // Holding register: load a punctured pair, shift the pending bit forward on each accepted output
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= 2'd0;
            bit0_q <= 1'b0;
            bit1_q <= 1'b0;
            last_q <= 1'b0;
        end else if (load) begin
            last_q <= last_in;
            case (mask)
                2'b11: begin
                    bit0_q <= c0;
                    bit1_q <= c1;
                    cnt_q  <= 2'd2;
                end
                2'b01: begin
                    bit0_q <= c0;
                    cnt_q  <= 2'd1;
                end
                2'b10: begin
                    bit0_q <= c1;
                    cnt_q  <= 2'd1;
                end
                default: cnt_q <= 2'd0;
            endcase
        end else if (out_valid && out_ready) begin
            if (cnt_q == 2'd2) begin
                bit0_q <= bit1_q;
                cnt_q  <= 2'd1;
            end else begin
                cnt_q <= 2'd0;
            end
        end
    end

    assign empty     = (cnt_q == 2'd0);
    assign out_valid = (cnt_q != 2'd0);
    assign out_bit   = bit0_q;
    assign out_last  = last_q && (cnt_q == 2'd1);

endmodule

// File: rtl/conv_encoder_punct.sv
// Frame-based convolutional encoder with selectable constraint length and
// punctured rate. Each accepted start latches the configuration; the frame's
// information bits are encoded one per step, followed by K-1 zero tail steps
// that flush the shift register. Coded bits leave through the serializer.
module conv_encoder_punct
    import conv_enc_pkg::*;
#(
    parameter int LEN_W = 8,
    parameter int MAX_K = 7
) (
    input  logic                clk,
    input  logic                rst_n,
    conv_encoder_punct_if.slave bus
);
    localparam int SR_W = MAX_K - 1;

    enc_state_e       state_q;
    enc_state_e       state_d;
    logic [SR_W-1:0]  sr_q;
    logic [LEN_W-1:0] bit_cnt_q;
    logic [LEN_W-1:0] len_q;
    logic [2:0]       tail_cnt_q;
    logic [2:0]       k_q;
    logic [1:0]       cfg_k_q;
    logic [1:0]       rate_q;
    logic [1:0]       p_q;
    logic [1:0]       p_next;

    logic             ser_empty;
    logic             start_acc;
    logic             step_data;
    logic             step_tail;
    logic             step;
    logic             step_bit;
    logic             last_data;
    logic             last_tail;
    logic             last_handshake;
    logic [1:0]       mask;
    logic [GEN_W-1:0] g0;
    logic [GEN_W-1:0] g1;
    logic             c0;
    logic             c1;

    // Step qualification: a step happens only while the serializer is empty
    always_comb begin
        start_acc      = (state_q == ST_IDLE) && bus.start && (bus.frame_len != '0);
        step_data      = (state_q == ST_DATA) && bus.in_valid && ser_empty;
        step_tail      = (state_q == ST_TAIL) && ser_empty;
        step           = step_data || step_tail;
        step_bit       = step_data ? bus.in_data : 1'b0;
        last_data      = (bit_cnt_q == len_q - LEN_W'(1));
        last_tail      = (tail_cnt_q == k_q - 3'd2);
        last_handshake = bus.out_valid && bus.out_ready && bus.out_last;
        mask           = PUNCT_MASK_TBL[rate_q][p_q];
        p_next         = (p_q == PUNCT_PERIOD_TBL[rate_q] - 2'd1) ? 2'd0 : p_q + 2'd1;
    end

    // Parity of the current bit and shift register against both left-aligned generators
    always_comb begin
        g0 = GEN0_TBL[cfg_k_q];
        g1 = GEN1_TBL[cfg_k_q];
        c0 = step_bit & g0[GEN_W-1];
        c1 = step_bit & g1[GEN_W-1];
        for (int i = 0; i < SR_W; i++) begin
            if (i < GEN_W - 1) begin
                c0 = c0 ^ (sr_q[i] & g0[GEN_W-2-i]);
                c1 = c1 ^ (sr_q[i] & g1[GEN_W-2-i]);
            end
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: data bits, then K-1 tail steps, then wait for the final coded bit to leave
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start_acc)                state_d = ST_DATA;
            ST_DATA:  if (step_data && last_data)   state_d = ST_TAIL;
            ST_TAIL:  if (step_tail && last_tail)   state_d = ST_DRAIN;
            ST_DRAIN: if (last_handshake)           state_d = ST_IDLE;
            default:                                state_d = ST_IDLE;
        endcase
    end

    // Frame configuration, shift register, step counters and puncture index
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cfg_k_q    <= 2'd0;
            k_q        <= 3'd0;
            rate_q     <= 2'd0;
            len_q      <= '0;
            sr_q       <= '0;
            bit_cnt_q  <= '0;
            tail_cnt_q <= 3'd0;
            p_q        <= 2'd0;
        end else if (start_acc) begin
            cfg_k_q    <= bus.constraint_sel;
            k_q        <= k_of(bus.constraint_sel);
            rate_q     <= bus.rate_sel;
            len_q      <= bus.frame_len;
            sr_q       <= '0;
            bit_cnt_q  <= '0;
            tail_cnt_q <= 3'd0;
            p_q        <= 2'd0;
        end else if (step) begin
            sr_q <= {sr_q[SR_W-2:0], step_bit};
            p_q  <= p_next;
            if (step_data) begin
                bit_cnt_q <= bit_cnt_q + LEN_W'(1);
            end
            if (step_tail) begin
                tail_cnt_q <= tail_cnt_q + 3'd1;
            end
        end
    end

    assign bus.busy     = (state_q != ST_IDLE);
    assign bus.in_ready = (state_q == ST_DATA) && ser_empty;

    conv_puncture_ser u_ser (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (step),
        .c0        (c0),
        .c1        (c1),
        .mask      (mask),
        .last_in   (step_tail && last_tail),
        .empty     (ser_empty),
        .out_valid (bus.out_valid),
        .out_ready (bus.out_ready),
        .out_bit   (bus.out_bit),
        .out_last  (bus.out_last)
    );

endmodule

// File: tb/tb_conv_encoder_punct.sv
// Bench for conv_encoder_punct: frames are encoded by a polynomial-level model
// into an expected {bit,last} queue; one compare process checks every accepted
// coded bit, output stability under back-pressure and in_ready exclusivity.
module tb_conv_encoder_punct;

    localparam int LEN_W = 8;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    conv_encoder_punct_if #(.LEN_W(LEN_W)) bus ();

    conv_encoder_punct #(.LEN_W(LEN_W), .MAX_K(7)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int         vec_cnt = 0;
    int         err_cnt = 0;
    logic [1:0] exp_q[$];
    logic [1:0] mdl_q[$];
    logic       got_q[$];
    int         ready_mode = 0;
    int         stall_req = 0;
    int         stall_served = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        vec_cnt++;
        if (got !== want) begin
            err_cnt++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, got, want);
        end
    endtask

    // Reference encoder: octal generators applied to a window of the last K input bits
    function automatic void model_frame(input int ksel, input int rsel, input int len,
                                        input logic [255:0] bits);
        int k, g0, g1, hist, win, r, period, p;
        logic in_b, c0, c1;
        logic [1:0] e;
        mdl_q.delete();
        case (ksel)
            0:       begin k = 3; g0 = 'o7;   g1 = 'o5;   end
            1:       begin k = 4; g0 = 'o15;  g1 = 'o17;  end
            2:       begin k = 5; g0 = 'o23;  g1 = 'o35;  end
            default: begin k = 7; g0 = 'o171; g1 = 'o133; end
        endcase
        r      = (rsel == 3) ? 0 : rsel;
        period = r + 1;
        p      = 0;
        hist   = 0;
        for (int s = 0; s < len + k - 1; s++) begin
            in_b = (s < len) ? bits[s] : 1'b0;
            win  = (int'(in_b) << (k - 1)) | hist;
            c0   = ^(win & g0);
            c1   = ^(win & g1);
            hist = win >> 1;
            if (r == 0 || p == 0) begin
                mdl_q.push_back({c0, 1'b0});
                mdl_q.push_back({c1, 1'b0});
            end else if (p == 1) begin
                mdl_q.push_back({c0, 1'b0});
            end else begin
                mdl_q.push_back({c1, 1'b0});
            end
            p = (p + 1) % period;
        end
        e = mdl_q.pop_back();
        e[0] = 1'b1;
        mdl_q.push_back(e);
    endfunction

    function automatic logic [31:0] mdl_bits();
        logic [31:0] v = '0;
        foreach (mdl_q[i]) v = {v[30:0], mdl_q[i][1]};
        return v;
    endfunction

    function automatic logic [31:0] mdl_lasts();
        logic [31:0] v = '0;
        foreach (mdl_q[i]) v = {v[30:0], mdl_q[i][0]};
        return v;
    endfunction

    function automatic logic [31:0] got_bits();
        logic [31:0] v = '0;
        foreach (got_q[i]) v = {v[30:0], got_q[i]};
        return v;
    endfunction

    // Downstream ready: always-on, random, with optional 5-cycle stall while a bit waits
    initial begin
        int stall_cnt;
        stall_cnt     = 0;
        bus.out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (stall_req != stall_served && bus.out_valid) begin
                stall_served = stall_req;
                stall_cnt    = 5;
            end
            if (stall_cnt > 0) begin
                bus.out_ready = 1'b0;
                stall_cnt--;
            end else if (ready_mode == 0) begin
                bus.out_ready = 1'b1;
            end else begin
                bus.out_ready = 1'($urandom_range(0, 1));
            end
        end
    end

    // Compare process: every accepted coded bit against the model, plus stall and in_ready rules
    initial begin
        logic prev_stall;
        logic prev_bit;
        logic prev_last;
        logic [1:0] e;
        prev_stall = 1'b0;
        prev_bit   = 1'b0;
        prev_last  = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    check("stall_hold", 32'({bus.out_valid, bus.out_bit, bus.out_last}),
                          32'({1'b1, prev_bit, prev_last}));
                end
                if (bus.out_valid) begin
                    check("in_ready_while_occupied", 32'(bus.in_ready), 32'd0);
                end
                if (bus.out_valid && bus.out_ready) begin
                    if (exp_q.size() == 0) begin
                        vec_cnt++;
                        err_cnt++;
                        $display("[TB] FAIL extra_bit: got bit %0b last %0b, expected none",
                                 bus.out_bit, bus.out_last);
                    end else begin
                        e = exp_q.pop_front();
                        check($sformatf("coded_bit[%0d]", got_q.size()),
                              32'({bus.out_bit, bus.out_last}), 32'(e));
                    end
                    got_q.push_back(bus.out_bit);
                end
                prev_stall = bus.out_valid && !bus.out_ready;
                prev_bit   = bus.out_bit;
                prev_last  = bus.out_last;
            end
        end
    end

    task automatic startFrame(input int ksel, input int rsel, input int len);
        @(posedge clk);
        #1;
        bus.constraint_sel = 2'(ksel);
        bus.rate_sel       = 2'(rsel);
        bus.frame_len      = LEN_W'(len);
        bus.start          = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    task automatic feedBit(input logic b, output bit ok);
        int guard;
        if ($urandom_range(0, 3) == 0) begin
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        guard = 0;
        do begin
            @(negedge clk);
            guard++;
        end while (!bus.in_ready && guard < 200);
        ok = bus.in_ready;
        if (!ok) begin
            vec_cnt++;
            err_cnt++;
            $display("[TB] FAIL in_ready_timeout: got in_ready 0, expected 1 within 200 cycles");
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic applyStimulus(input int ksel, input int rsel, input int len,
                                 input logic [255:0] bits, input int mode, input bit mid_start);
        int guard;
        bit ok;
        ready_mode = mode;
        model_frame(ksel, rsel, len, bits);
        foreach (mdl_q[i]) exp_q.push_back(mdl_q[i]);
        got_q.delete();
        startFrame(ksel, rsel, len);
        check("busy_after_start", 32'(bus.busy), 32'd1);
        for (int i = 0; i < len; i++) begin
            feedBit(bits[i], ok);
            if (!ok) return;
            if (mid_start && i == 1) begin
                bus.start          = 1'b1;
                bus.rate_sel       = 2'((rsel + 1) % 3);
                bus.constraint_sel = 2'(3 - ksel);
                bus.frame_len      = LEN_W'(3);
                @(posedge clk);
                #1;
                bus.start = 1'b0;
            end
        end
        guard = 0;
        while (bus.busy && guard < 100 + len * 20) begin
            @(negedge clk);
            guard++;
        end
        check("busy_low_after_frame", 32'(bus.busy), 32'd0);
    endtask

    task automatic checkOutput(input string name, input int n_bits);
        check({name, "_expected_drained"}, 32'(exp_q.size()), 32'd0);
        check({name, "_bit_count"}, 32'(got_q.size()), 32'(n_bits));
    endtask

    initial begin
        logic [255:0] b1011;
        logic [255:0] bk7;
        logic [255:0] bits;
        logic [7:0]   k7pat;
        int           ksel, rsel, len, mode;
        bit           ok;

        bus.constraint_sel = 2'd0;
        bus.rate_sel       = 2'd0;
        bus.frame_len      = '0;
        bus.start          = 1'b0;
        bus.in_valid       = 1'b0;
        bus.in_data        = 1'b0;
        rst_n              = 1'b0;

        b1011 = '0;
        b1011[0] = 1'b1; b1011[1] = 1'b0; b1011[2] = 1'b1; b1011[3] = 1'b1;
        k7pat = 8'b01000101;
        bk7 = '0;
        for (int i = 0; i < 8; i++) bk7[i] = k7pat[7-i];

        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", 32'({bus.busy, bus.in_ready, bus.out_valid, bus.out_bit, bus.out_last}), 32'd0);
        rst_n = 1'b1;

        // Hand-derived sequences pinning the model
        model_frame(0, 0, 4, b1011);
        check("model_k3_r12_bits", mdl_bits(), 32'b111000010111);
        check("model_k3_r12_last", mdl_lasts(), 32'b000000000001);
        model_frame(0, 1, 4, b1011);
        check("model_k3_r23_bits", mdl_bits(), 32'b111000011);
        model_frame(0, 2, 1, b1011);
        check("model_k3_r34_len1", mdl_bits(), 32'b1111);

        $display("[TB] scenario 1: K=3 rate 1/2");
        applyStimulus(0, 0, 4, b1011, 0, 0);
        checkOutput("s1", 12);
        check("s1_literal", got_bits(), 32'b111000010111);

        $display("[TB] scenario 2: K=3 rate 2/3");
        applyStimulus(0, 1, 4, b1011, 0, 0);
        checkOutput("s2", 9);
        check("s2_literal", got_bits(), 32'b111000011);

        $display("[TB] scenario 3: back-pressure with 5-cycle stall");
        stall_req++;
        applyStimulus(0, 0, 4, b1011, 2, 0);
        checkOutput("s3", 12);
        check("s3_literal", got_bits(), 32'b111000010111);

        $display("[TB] scenario 4: K=7 rate 1/2");
        applyStimulus(3, 0, 8, bk7, 0, 0);
        checkOutput("s4", 28);

        $display("[TB] length-1 frame at rate 3/4");
        applyStimulus(0, 2, 1, b1011, 0, 0);
        checkOutput("len1", 4);
        check("len1_literal", got_bits(), 32'b1111);

        $display("[TB] scenario 5: reset mid-frame");
        ready_mode = 0;
        bits = {$urandom(), $urandom(), $urandom(), $urandom(),
                $urandom(), $urandom(), $urandom(), $urandom()};
        model_frame(2, 0, 8, bits);
        foreach (mdl_q[i]) exp_q.push_back(mdl_q[i]);
        got_q.delete();
        startFrame(2, 0, 8);
        feedBit(1'b1, ok);
        feedBit(1'b1, ok);
        rst_n = 1'b0;
        #1;
        check("async_reset_outputs",
              32'({bus.busy, bus.in_ready, bus.out_valid, bus.out_bit, bus.out_last}), 32'd0);
        exp_q.delete();
        got_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        applyStimulus(0, 0, 4, b1011, 0, 0);
        checkOutput("s5", 12);
        check("s5_literal", got_bits(), 32'b111000010111);

        $display("[TB] scenario 6: zero-length start and start while busy");
        got_q.delete();
        startFrame(0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("len0_idle", 32'({bus.busy, bus.out_valid}), 32'd0);
        end
        check("len0_no_output", 32'(got_q.size()), 32'd0);
        bits = {$urandom(), $urandom(), $urandom(), $urandom(),
                $urandom(), $urandom(), $urandom(), $urandom()};
        applyStimulus(1, 0, 6, bits, 0, 1);
        checkOutput("s6", 18);

        $display("[TB] randomized frames");
        for (int f = 0; f < 20; f++) begin
            ksel = int'($urandom_range(0, 3));
            rsel = int'($urandom_range(0, 3));
            len  = int'($urandom_range(1, 40));
            mode = int'($urandom_range(0, 2));
            bits = {$urandom(), $urandom(), $urandom(), $urandom(),
                    $urandom(), $urandom(), $urandom(), $urandom()};
            if (mode == 2) stall_req++;
            applyStimulus(ksel, rsel, len, bits, mode, 1'b0);
            checkOutput($sformatf("rand%0d", f), mdl_q.size());
        end

        repeat (4) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
